regfile_wb_queue: RTL and testbench

Writeback queue that is the writer end of the register file's single write port. It buffers results from long-latency units (multiplier/divider, load unit) and drains them into the register file only in cycles where the main pipeline is not writing back. Queued writes to a register are cancelled when the pipeline writes that register later. The queue also reports pending-write hazards for the decode stage's two source operands.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_queue.sv | 111 +++++++++++
 tb/tb_regfile_wb_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and widths used by the writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // 'reg' is a reserved word, so the destination field is named rd.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the register file write port from long-latency units;
// the main pipeline always wins the port and cancels older queued writes to the same register.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       pipe_reg_write,
  input  logic [ADDR_W-1:0]          pipe_write_reg,
  input  logic [DATA_W-1:0]          pipe_write_data,
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          src1_reg,
  input  logic [ADDR_W-1:0]          src2_reg,
  output logic                       src1_busy,
  output logic                       src2_busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t              r_q [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  wb_entry_t              w_head;
  logic                   w_enq;
  logic                   w_pop;
  logic                   w_kill;
  logic                   w_busy1;
  logic                   w_busy2;

  assign w_head   = r_q[r_head];
  assign in_ready = !rst && (r_count < FULL_CNT);
  // r0 writes complete the handshake but are never stored.
  assign w_enq    = in_valid && in_ready && (in_reg != REG_ZERO);
  assign w_pop    = !rst && !pipe_reg_write && (r_count != '0);
  assign w_kill   = pipe_reg_write && (pipe_write_reg != REG_ZERO);
  assign count    = r_count;

  always_comb begin
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    if (!rst) begin
      if (pipe_reg_write) begin
        reg_write  = 1'b1;
        write_reg  = pipe_write_reg;
        write_data = pipe_write_data;
      end else if ((r_count != '0) && w_head.live) begin
        reg_write  = 1'b1;
        write_reg  = w_head.rd;
        write_data = w_head.data;
      end
    end
  end

  // Popped slots have live cleared, so a plain scan over all slots sees only stored entries.
  always_comb begin
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q[i].live && (r_q[i].rd == src1_reg)) w_busy1 = 1'b1;
      if (r_q[i].live && (r_q[i].rd == src2_reg)) w_busy2 = 1'b1;
    end
  end

  assign src1_busy = !rst && (src1_reg != REG_ZERO) && w_busy1;
  assign src2_busy = !rst && (src2_reg != REG_ZERO) && w_busy2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i].live <= 1'b0;
    end else begin
      if (w_pop) begin
        r_q[r_head].live <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      if (w_kill) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_q[i].rd == pipe_write_reg) r_q[i].live <= 1'b0;
      end
      // Enqueue is younger than a same-cycle pipeline write, so it overrides the kill.
      if (w_enq) begin
        r_q[r_tail] <= '{live: 1'b1, rd: in_reg, data: in_data};
        r_tail      <= r_tail + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with hand-computed expected values.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        pipe_reg_write;
  logic [4:0]  pipe_write_reg;
  logic [31:0] pipe_write_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  src1_reg;
  logic [4:0]  src2_reg;
  logic        src1_busy;
  logic        src2_busy;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .pipe_reg_write(pipe_reg_write), .pipe_write_reg(pipe_write_reg),
    .pipe_write_data(pipe_write_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_busy(src1_busy), .src2_busy(src2_busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we"},   64'(reg_write),  64'(we));
    chk({tag, ".reg"},  64'(write_reg),  64'(r));
    chk({tag, ".data"}, 64'(write_data), 64'(d));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    pipe_reg_write = 1'b0; pipe_write_reg = '0; pipe_write_data = '0;
    src1_reg = '0; src2_reg = '0;
    step(); step();
    settle();
    chk("rst.in_ready", 64'(in_ready), 64'(0));
    chk_wr("rst.out", 1'b0, 5'd0, 32'd0);
    chk("rst.count", 64'(count), 64'(0));

    rst = 1'b0;
    settle();
    chk("idle.in_ready", 64'(in_ready), 64'(1));
    chk_wr("idle.out", 1'b0, 5'd0, 32'd0);

    // Basic drain
    in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    settle();
    chk("drain.count1", 64'(count), 64'(1));
    chk_wr("drain.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk("drain.count0", 64'(count), 64'(0));
    chk_wr("drain.after", 1'b0, 5'd0, 32'd0);

    // Pipeline priority
    in_valid = 1'b1; in_reg = 5'd3; in_data = 32'h11;
    step();
    in_valid = 1'b0;
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd7; pipe_write_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_wr("prio.pipe", 1'b1, 5'd7, 32'h22);
      chk("prio.count", 64'(count), 64'(1));
      step();
    end
    pipe_reg_write = 1'b0;
    settle();
    chk_wr("prio.q", 1'b1, 5'd3, 32'h11);
    step();
    chk("prio.count0", 64'(count), 64'(0));

    // Kill
    in_valid = 1'b1; in_reg = 5'd4; in_data = 32'hAA;
    step();
    in_valid = 1'b0;
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd4; pipe_write_data = 32'hBB;
    src1_reg = 5'd4;
    settle();
    chk("kill.busy_before", 64'(src1_busy), 64'(1));
    chk_wr("kill.pipe", 1'b1, 5'd4, 32'hBB);
    step();
    pipe_reg_write = 1'b0;
    settle();
    chk("kill.count1", 64'(count), 64'(1));
    chk("kill.we", 64'(reg_write), 64'(0));
    chk("kill.busy_after", 64'(src1_busy), 64'(0));
    step();
    chk("kill.count0", 64'(count), 64'(0));
    chk("kill.we2", 64'(reg_write), 64'(0));

    // Same-cycle ordering: enqueue is younger than the pipe write
    in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h1;
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd9; pipe_write_data = 32'h2;
    src1_reg = 5'd9;
    settle();
    chk_wr("order.pipe", 1'b1, 5'd9, 32'h2);
    chk("order.busy_noenq", 64'(src1_busy), 64'(0));
    step();
    in_valid = 1'b0; pipe_reg_write = 1'b0;
    settle();
    chk("order.busy", 64'(src1_busy), 64'(1));
    chk_wr("order.q", 1'b1, 5'd9, 32'h1);
    step();
    chk("order.count0", 64'(count), 64'(0));

    // Full, r0 and enqueue+pop wrapping
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd1; pipe_write_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'(32'h100 + i);
      step();
    end
    in_reg = 5'd14; in_data = 32'h999;
    settle();
    chk("full.count", 64'(count), 64'(4));
    chk("full.in_ready", 64'(in_ready), 64'(0));
    src1_reg = 5'd12; src2_reg = 5'd20;
    settle();
    chk("full.busy1", 64'(src1_busy), 64'(1));
    chk("full.busy2", 64'(src2_busy), 64'(0));
    step();
    chk("full.noenq", 64'(count), 64'(4));
    in_valid = 1'b0; pipe_reg_write = 1'b0;
    settle();
    chk_wr("full.pop0", 1'b1, 5'd10, 32'h100);
    step();
    chk("full.count3", 64'(count), 64'(3));
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h77;
    pipe_reg_write = 1'b1;
    settle();
    chk("r0.in_ready", 64'(in_ready), 64'(1));
    step();
    chk("r0.count", 64'(count), 64'(3));
    pipe_reg_write = 1'b0;
    in_reg = 5'd15; in_data = 32'h55;
    settle();
    chk_wr("both.pop", 1'b1, 5'd11, 32'h101);
    step();
    in_valid = 1'b0;
    chk("both.count", 64'(count), 64'(3));
    settle();
    chk_wr("wrap.e12", 1'b1, 5'd12, 32'h102);
    step();
    chk_wr("wrap.e13", 1'b1, 5'd13, 32'h103);
    step();
    chk_wr("wrap.e15", 1'b1, 5'd15, 32'h55);
    step();
    chk("wrap.count0", 64'(count), 64'(0));
    chk_wr("wrap.idle", 1'b0, 5'd0, 32'd0);

    // Reset mid-run
    pipe_reg_write = 1'b1; pipe_write_reg = 5'd2; pipe_write_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_reg = 5'(20 + i); in_data = 32'(32'h200 + i);
      step();
    end
    in_valid = 1'b0; pipe_reg_write = 1'b0;
    rst = 1'b1; src1_reg = 5'd21;
    settle();
    chk("mrst.count3", 64'(count), 64'(3));
    chk_wr("mrst.during", 1'b0, 5'd0, 32'd0);
    chk("mrst.in_ready", 64'(in_ready), 64'(0));
    chk("mrst.busy", 64'(src1_busy), 64'(0));
    step();
    rst = 1'b0;
    settle();
    chk("mrst.count0", 64'(count), 64'(0));
    chk("mrst.busy_after", 64'(src1_busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("mrst.nowrite", 64'(reg_write), 64'(0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
